// File: rtl/ok_wire_out_bank.sv
// Bank of N_CH wire-out endpoints plus a status word, published atomically on host wire update.
// Optional shadow register lets the user freeze a coherent snapshot ahead of the host update.
module ok_wire_out_bank #(
  parameter int         N_CH         = 4,
  parameter logic [7:0] BASE_ADDR    = 8'h20,
  parameter logic [7:0] STAT_ADDR    = 8'h3F,
  parameter int         CAPTURE_MODE = 0
) (
  input  logic               ti_clock,
  input  logic               ti_reset,
  input  logic [7:0]         ti_addr,
  input  logic               ti_wireupdate,
  output logic [16:0]        ok2,
  input  logic [16*N_CH-1:0] ep_datain,
  input  logic               ep_capture,
  output logic               ep_published
);

  if (N_CH < 1 || N_CH > 15) begin : g_bad_nch
    $error("ok_wire_out_bank: N_CH must be 1..15");
  end
  if (int'(BASE_ADDR) < 32 || int'(BASE_ADDR) + N_CH - 1 > 63 ||
      int'(STAT_ADDR) < 32 || int'(STAT_ADDR) > 63) begin : g_bad_addr
    $error("ok_wire_out_bank: endpoint address outside 0x20..0x3F");
  end
  if (int'(STAT_ADDR) >= int'(BASE_ADDR) &&
      int'(STAT_ADDR) < int'(BASE_ADDR) + N_CH) begin : g_bad_stat
    $error("ok_wire_out_bank: STAT_ADDR collides with a channel address");
  end

  logic [15:0]     r_hold   [N_CH];
  logic [15:0]     r_shadow [N_CH];
  logic [N_CH-1:0] r_chg;
  logic            r_ovr;
  logic            r_pending;
  logic            r_published;

  logic            w_cap;
  logic [15:0]     w_src [N_CH];
  logic [15:0]     w_stat;
  logic [15:0]     w_rd;

  assign w_cap = (CAPTURE_MODE != 0) && ep_capture;

  // hold always loads from the pre-edge shadow, so a same-cycle capture lands in the next publish
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_src[i] = (CAPTURE_MODE != 0) ? r_shadow[i] : ep_datain[16*i +: 16];
    end
  end

  always_comb begin
    w_stat     = '0;
    w_stat[15] = r_ovr;
    for (int i = 0; i < N_CH; i++) begin
      w_stat[i] = r_chg[i];
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ti_addr == 8'(int'(BASE_ADDR) + i)) begin
        w_rd = r_hold[i];
      end
    end
    if (ti_addr == STAT_ADDR) begin
      w_rd = w_stat;
    end
  end

  assign ok2          = {1'b0, w_rd};
  assign ep_published = r_published;

  always_ff @(posedge ti_clock) begin
    if (ti_reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_hold[i]   <= '0;
        r_shadow[i] <= '0;
      end
      r_chg       <= '0;
      r_ovr       <= 1'b0;
      r_pending   <= 1'b0;
      r_published <= 1'b0;
    end else begin
      r_published <= ti_wireupdate;
      if (w_cap) begin
        for (int i = 0; i < N_CH; i++) begin
          r_shadow[i] <= ep_datain[16*i +: 16];
        end
      end
      if (ti_wireupdate) begin
        for (int i = 0; i < N_CH; i++) begin
          r_hold[i] <= w_src[i];
          r_chg[i]  <= (w_src[i] != r_hold[i]);
        end
        r_ovr     <= 1'b0;
        r_pending <= w_cap;
      end else if (w_cap) begin
        if (r_pending) begin
          r_ovr <= 1'b1;
        end
        r_pending <= 1'b1;
      end
    end
  end

endmodule
